// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
//
// Three-master AHB bus arbiter: round-robin grant with master 0 as the default
// master, a beat limit that forces re-arbitration during long bursts, and
// locked sequences that hold the grant until the owner releases the lock.
//
// State table
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_ARB     | no transfer in progress; grant re-evaluated round-robin
//   ST_BURST   | owner is running an unlocked burst; beats are counted
//   ST_LOCKED  | owner is running a locked sequence; grant is pinned
//
// Ports
//   HCLK       in   bus clock, rising-edge active
//   HRESETn    in   asynchronous active-low reset
//   HBUSREQ    in   [2:0] bus requests (0 RISC, 1 DMA, 2 test master)
//   HLOCK      in   [2:0] locked-transfer requests, same bit order
//   HTRANS     in   [1:0] transfer type of the current address-phase owner
//   HREADY     in   transfer done; every state update is gated by it
//   HGRANT     out  [2:0] one-hot grant, registered
//   HMASTER    out  [1:0] index of the address-phase owner, registered
//   HMASTLOCK  out  current address phase is locked, registered
//
// Parameter
//   MAX_BEATS  beats one master may hold the grant in an unlocked burst
//              before it is forced back into arbitration (4..255)
// ---------------------------------------------------------------------------
module ahb_arbiter #(
    parameter int MAX_BEATS = 16
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [2:0] HBUSREQ,
    input  logic [2:0] HLOCK,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic [2:0] HGRANT,
    output logic [1:0] HMASTER,
    output logic       HMASTLOCK
);

    localparam logic [1:0] ST_ARB    = 2'd0;
    localparam logic [1:0] ST_BURST  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [7:0] BEAT_MAX  = 8'(MAX_BEATS);

    logic [1:0] state_q,    state_d;
    logic [2:0] grant_q,    grant_d;
    logic [1:0] master_q,   master_d;
    logic       mastlock_q, mastlock_d;
    logic [7:0] beat_q,     beat_d;

    logic [1:0] grant_idx;
    logic       owner_lock;
    logic       owner_req;
    logic       xfer_active;
    logic [7:0] beat_inc;
    logic [7:0] beat_next;
    logic [2:0] rr_grant;
    logic [2:0] owner_grant;

    // Index of a one-hot grant vector. Anything that is not 010/100 maps to
    // master 0 so HMASTER can never carry the unused encoding 11.
    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b001;
        endcase
        return oh;
    endfunction

    // Round-robin pick starting at the master after `from`, wrapping 2->0.
    // `from` itself is checked last, so a master that just finished is only
    // re-granted when nobody else wants the bus. No requests -> master 0.
    function automatic logic [2:0] rr_pick(input logic [1:0] from,
                                           input logic [2:0] req);
        logic [2:0] pick;
        case (from)
            2'd0: begin
                if      (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else             pick = 3'b001;
            end
            2'd1: begin
                if      (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else             pick = 3'b001;
            end
            default: begin
                if      (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else             pick = 3'b001;
            end
        endcase
        return pick;
    endfunction

    // The owner is the address-phase master (HMASTER); HTRANS belongs to it.
    assign grant_idx   = onehot_to_idx(grant_q);
    assign owner_lock  = HLOCK[master_q];
    assign owner_req   = HBUSREQ[master_q];
    assign xfer_active = (HTRANS == TR_NONSEQ) || (HTRANS == TR_SEQ);
    assign beat_inc    = (beat_q >= BEAT_MAX) ? BEAT_MAX : beat_q + 8'd1;
    assign beat_next   = xfer_active ? beat_inc : beat_q;
    assign rr_grant    = rr_pick(master_q, HBUSREQ);
    assign owner_grant = idx_to_onehot(master_q);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        master_d   = master_q;
        mastlock_d = mastlock_q;
        beat_d     = beat_q;

        if (HREADY) begin
            // Ownership follows the grant one HREADY cycle later.
            master_d   = grant_idx;
            mastlock_d = HLOCK[grant_idx];

            case (state_q)
                ST_ARB: begin
                    if (HTRANS == TR_NONSEQ) begin
                        // Keep the grant with the master that just started,
                        // even if the idle rotation had already moved on.
                        state_d = owner_lock ? ST_LOCKED : ST_BURST;
                        grant_d = owner_grant;
                        beat_d  = 8'd1;
                    end else begin
                        grant_d = rr_grant;
                        beat_d  = 8'd0;
                    end
                end

                ST_BURST: begin
                    beat_d = beat_next;
                    // A lock request outranks the beat limit.
                    if (owner_lock && (HTRANS != TR_IDLE)) begin
                        state_d = ST_LOCKED;
                    end else if ((HTRANS == TR_IDLE) || !owner_req ||
                                 (beat_next == BEAT_MAX)) begin
                        state_d = ST_ARB;
                        grant_d = rr_grant;
                    end
                end

                ST_LOCKED: begin
                    beat_d = beat_next;
                    if (!owner_lock &&
                        ((HTRANS == TR_IDLE) || (HTRANS == TR_NONSEQ))) begin
                        state_d = ST_ARB;
                        grant_d = rr_grant;
                    end
                end

                default: begin
                    state_d = ST_ARB;
                    grant_d = 3'b001;
                    beat_d  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_ARB;
            grant_q    <= 3'b001;
            master_q   <= 2'd0;
            mastlock_q <= 1'b0;
            beat_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
            beat_q     <= beat_d;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = master_q;
    assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter
//
// Bench for ahb_arbiter. Each driven cycle pushes the expected
// {HGRANT, HMASTER, HMASTLOCK} from a reference model into a queue; after the
// clock edge the entry is popped and compared with the DUT. Directed
// scenarios add fixed-value checks for reset, round-robin order, beat limit,
// wait states, locking, request drop and the default master.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter;

    localparam int MAXB = 16;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [2:0] HBUSREQ;
    logic [2:0] HLOCK;
    logic [1:0] HTRANS;
    logic       HREADY;
    logic [2:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] exp_q[$];

    // reference model state
    int         m_st;      // 0 arb, 1 burst, 2 locked
    int         m_beats;
    logic [1:0] m_g;       // granted index
    logic [1:0] m_m;       // owner index
    logic       m_ml;

    logic [2:0] rr_g [9] = '{3'b001, 3'b010, 3'b010,
                             3'b010, 3'b100, 3'b100,
                             3'b100, 3'b001, 3'b001};
    logic [1:0] rr_m [9] = '{2'd0, 2'd0, 2'd1,
                             2'd1, 2'd1, 2'd2,
                             2'd2, 2'd2, 2'd0};

    always #5 HCLK = ~HCLK;

    ahb_arbiter #(.MAX_BEATS(MAXB)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [2:0] oh(input logic [1:0] i);
        return (i == 2'd1) ? 3'b010 : (i == 2'd2) ? 3'b100 : 3'b001;
    endfunction

    // Search the three masters starting after `last`; `last` itself comes
    // third, the default master when nothing is requested.
    function automatic logic [1:0] rr_model(input logic [1:0] last,
                                            input logic [2:0] req);
        logic [1:0] c;
        for (int d = 1; d <= 3; d++) begin
            c = 2'((int'(last) + d) % 3);
            if (req[c]) return c;
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_st = 0; m_beats = 0; m_g = 2'd0; m_m = 2'd0; m_ml = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] req, input logic [2:0] lock,
                              input logic [1:0] tr, input logic rdy);
        int         ns, nb;
        logic [1:0] ng;
        logic       act;
        if (!rdy) return;
        ns  = m_st;
        nb  = m_beats;
        ng  = m_g;
        act = (tr == T_SEQ) || (tr == T_NONSEQ);
        if (m_st == 0) begin
            if (tr == T_NONSEQ) begin
                ns = lock[m_m] ? 2 : 1;
                nb = 1;
                ng = m_m;
            end else begin
                ng = rr_model(m_m, req);
                nb = 0;
            end
        end else if (m_st == 1) begin
            if (act) nb = (m_beats + 1 > MAXB) ? MAXB : m_beats + 1;
            if (lock[m_m] && tr != T_IDLE) ns = 2;
            else if (tr == T_IDLE || !req[m_m] || nb == MAXB) begin
                ns = 0;
                ng = rr_model(m_m, req);
            end
        end else begin
            if (act) nb = (m_beats + 1 > MAXB) ? MAXB : m_beats + 1;
            if (!lock[m_m] && (tr == T_IDLE || tr == T_NONSEQ)) begin
                ns = 0;
                ng = rr_model(m_m, req);
            end
        end
        m_ml    = lock[m_g];
        m_m     = m_g;
        m_g     = ng;
        m_st    = ns;
        m_beats = nb;
    endtask

    task automatic step(input string tag, input logic [2:0] req,
                        input logic [2:0] lock, input logic [1:0] tr,
                        input logic rdy);
        logic [5:0] e;
        @(negedge HCLK);
        HBUSREQ = req;
        HLOCK   = lock;
        HTRANS  = tr;
        HREADY  = rdy;
        model_step(req, lock, tr, rdy);
        exp_q.push_back({oh(m_g), m_m, m_ml});
        @(posedge HCLK);
        #1;
        e = exp_q.pop_front();
        chk(tag, 32'({HGRANT, HMASTER, HMASTLOCK}), 32'(e));
        chk("grant_onehot", 32'($onehot(HGRANT)), 32'd1);
    endtask

    // Reset is asserted between edges with HREADY low; outputs must clear
    // before any clock edge arrives.
    task automatic do_reset();
        @(negedge HCLK);
        HREADY = 1'b0;
        HTRANS = T_SEQ;
        #2;
        HRESETn = 1'b0;
        #1;
        chk("rst_async", 32'({HGRANT, HMASTER, HMASTLOCK}), 32'(6'b001_00_0));
        @(posedge HCLK);
        #1;
        chk("rst_hold", 32'({HGRANT, HMASTER, HMASTLOCK}), 32'(6'b001_00_0));
        @(negedge HCLK);
        HRESETn = 1'b1;
        model_reset();
    endtask

    // Hand ownership to master 1 from the reset state.
    task automatic own_by_1();
        step("pre1", 3'b010, 3'b000, T_IDLE, 1'b1);
        step("pre2", 3'b010, 3'b000, T_IDLE, 1'b1);
        chk("pre_master", 32'(HMASTER), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        HRESETn = 1'b0;
        HBUSREQ = 3'b000;
        HLOCK   = 3'b000;
        HTRANS  = T_IDLE;
        HREADY  = 1'b0;
        model_reset();
        do_reset();

        // default master
        step("dm1", 3'b010, 3'b000, T_IDLE, 1'b1);
        chk("dm1_grant", 32'(HGRANT), 32'(3'b010));
        step("dm2", 3'b010, 3'b000, T_IDLE, 1'b1);
        step("dm3", 3'b000, 3'b000, T_IDLE, 1'b1);
        chk("dm3_grant", 32'(HGRANT), 32'(3'b001));
        step("dm4", 3'b000, 3'b000, T_IDLE, 1'b1);
        chk("dm4_master", 32'(HMASTER), 32'd0);

        // round robin, single NONSEQ bursts
        do_reset();
        for (int b = 0; b < 3; b++) begin
            for (int p = 0; p < 3; p++) begin
                step("rr", 3'b111, 3'b000, (p == 0) ? T_NONSEQ : T_IDLE, 1'b1);
                chk("rr_grant", 32'(HGRANT), 32'(rr_g[b*3+p]));
                chk("rr_master", 32'(HMASTER), 32'(rr_m[b*3+p]));
            end
        end

        // beat limit, unbroken SEQ
        do_reset();
        own_by_1();
        step("bl_ns", 3'b011, 3'b000, T_NONSEQ, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            step("bl_seq", 3'b011, 3'b000, T_SEQ, 1'b1);
            chk("bl_grant", 32'(HGRANT), 32'((k < 15) ? 3'b010 : 3'b001));
        end

        // beat limit with BUSY and wait states (counter frozen)
        do_reset();
        own_by_1();
        step("bw_ns", 3'b011, 3'b000, T_NONSEQ, 1'b1);
        for (int k = 0; k < 7; k++) step("bw_seq", 3'b011, 3'b000, T_SEQ, 1'b1);
        for (int k = 0; k < 2; k++) step("bw_busy", 3'b011, 3'b000, T_BUSY, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step("bw_wait", 3'($urandom_range(0, 7)), 3'b000, T_SEQ, 1'b0);
            chk("wait_grant", 32'(HGRANT), 32'(3'b010));
            chk("wait_master", 32'(HMASTER), 32'd1);
        end
        for (int k = 1; k <= 8; k++) begin
            step("bw_seq2", 3'b011, 3'b000, T_SEQ, 1'b1);
            chk("bw_grant", 32'(HGRANT), 32'((k < 8) ? 3'b010 : 3'b001));
        end

        // owner drops request while others assert
        do_reset();
        own_by_1();
        step("dr_ns", 3'b011, 3'b000, T_NONSEQ, 1'b1);
        step("dr_drop", 3'b101, 3'b000, T_SEQ, 1'b1);
        chk("drop_grant", 32'(HGRANT), 32'(3'b100));

        // lock wins over beat limit, counter saturates
        do_reset();
        own_by_1();
        step("ll_ns", 3'b011, 3'b000, T_NONSEQ, 1'b1);
        for (int k = 0; k < 14; k++) step("ll_seq", 3'b011, 3'b000, T_SEQ, 1'b1);
        step("ll_hit", 3'b011, 3'b010, T_SEQ, 1'b1);
        chk("lockhit_grant", 32'(HGRANT), 32'(3'b010));
        for (int k = 0; k < 20; k++) begin
            step("ll_sat", 3'b011, 3'b010, T_SEQ, 1'b1);
            chk("lsat_grant", 32'(HGRANT), 32'(3'b010));
        end
        step("ll_rel", 3'b011, 3'b000, T_IDLE, 1'b1);
        chk("lrel_grant", 32'(HGRANT), 32'(3'b001));

        // locked sequence by master 2 over 40 beats
        do_reset();
        step("lk_p1", 3'b100, 3'b100, T_IDLE, 1'b1);
        step("lk_p2", 3'b100, 3'b100, T_IDLE, 1'b1);
        step("lk_ns", 3'b111, 3'b100, T_NONSEQ, 1'b1);
        chk("lk_grant", 32'(HGRANT), 32'(3'b100));
        chk("lk_mlock", 32'(HMASTLOCK), 32'd1);
        for (int k = 0; k < 39; k++) begin
            step("lk_seq", 3'b111, 3'b100, T_SEQ, 1'b1);
            chk("lk_grant", 32'(HGRANT), 32'(3'b100));
            chk("lk_mlock", 32'(HMASTLOCK), 32'd1);
        end
        step("lk_drop", 3'b111, 3'b000, T_SEQ, 1'b1);
        chk("lkdrop_grant", 32'(HGRANT), 32'(3'b100));
        step("lk_idle", 3'b111, 3'b000, T_IDLE, 1'b1);
        chk("lkrel_grant", 32'(HGRANT), 32'(3'b001));

        // reset mid-burst with grant on master 1
        do_reset();
        own_by_1();
        step("rb_ns", 3'b010, 3'b000, T_NONSEQ, 1'b1);
        step("rb_seq", 3'b010, 3'b000, T_SEQ, 1'b1);
        chk("rb_grant", 32'(HGRANT), 32'(3'b010));
        do_reset();
        step("post_rst", 3'b011, 3'b000, T_SEQ, 1'b1);
        chk("post_rst_grant", 32'(HGRANT), 32'(3'b010));
        chk("post_rst_master", 32'(HMASTER), 32'd0);

        // random traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step("rand", 3'($urandom_range(0, 7)),
                 3'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 0),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
